line_slide_sequencer: RTL and testbench

//  Streaming controller for the column-slide stage of the syzyf datapath.

---
 rtl/line_slide_sequencer_pkg.sv | 17 +
 rtl/line_slide_sequencer_if.sv | 25 ++
 rtl/line_slide_sequencer_rotator.sv | 20 ++
 rtl/line_slide_sequencer.sv | 131 +++++++++++++
 tb/tb_line_slide_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/line_slide_sequencer_pkg.sv
// Shared constants and state type for the syzyf column-slide stage.
// OUT_W is tied to 2*IN_W so that every rotation keeps all of the input bits.
package syzyf_slider_pkg;

    localparam int COLS  = 8;
    localparam int IN_W  = 8;
    localparam int OUT_W = 2 * IN_W;
    localparam int STEP  = 2;
    localparam int IDX_W = $clog2(COLS);
    localparam int SH_W  = $clog2(OUT_W) + 1;

    typedef enum logic [0:0] {
        S_LOAD,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/line_slide_sequencer_if.sv
// Column input and slid-column output handshakes of the slide stage.
// The slave modport is the sequencer; the master modport is its environment.
interface line_slide_sequencer_if;
    import syzyf_slider_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/line_slide_sequencer_rotator.sv
// Combinational rotate-left of a zero-extended column by STEP*idx.
// Doubling the word turns the rotation into a plain shift followed by taking the upper half.
module line_rotator
    import syzyf_slider_pkg::*;
(
    input  logic [OUT_W-1:0] ext,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] rot
);

    logic [SH_W-1:0]    sh;
    logic [2*OUT_W-1:0] dbl;

    always_comb begin
        sh  = SH_W'(STEP * int'(idx));
        dbl = {ext, ext} << sh;
        rot = dbl[2*OUT_W-1:OUT_W];
    end

endmodule

// File: rtl/line_slide_sequencer.sv
// Column-slide sequencer: loads COLS columns, then drains them as rotated, registered outputs.
// Input and output phases never overlap, so one buffer is sufficient.
module line_slide_sequencer
    import syzyf_slider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    line_slide_sequencer_if.slave bus,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IN_W-1:0]  buf_q [COLS];
    logic [IN_W-1:0]  buf_d [COLS];
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic             in_fire;
    logic             out_fire;
    logic             load_done;
    logic [OUT_W-1:0] rot_data;

    assign in_fire   = (state_q == S_LOAD) && bus.in_valid;
    assign out_fire  = out_valid_q && bus.out_ready;
    assign load_done = in_fire && (wr_idx_q == IDX_LAST);

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        buf_d       = buf_q;
        frame_cnt_d = frame_cnt_q;
        if (flush) begin
            state_d  = S_LOAD;
            wr_idx_d = '0;
            rd_idx_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire) begin
                        buf_d[wr_idx_q] = bus.in_data;
                        if (load_done) begin
                            wr_idx_d = '0;
                            rd_idx_d = '0;
                            state_d  = S_DRAIN;
                        end else begin
                            wr_idx_d = wr_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                        if (out_last_q) begin
                            rd_idx_d    = '0;
                            state_d     = S_LOAD;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end
    end

    // Look ahead at the column that will be presented next so the output stays registered.
    line_rotator u_rotator (
        .ext (OUT_W'(buf_d[rd_idx_d])),
        .idx (rd_idx_d),
        .rot (rot_data)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load_done || (out_fire && !out_last_q)) begin
            out_valid_d = 1'b1;
            out_data_d  = rot_data;
            out_idx_d   = rd_idx_d;
            out_last_d  = (rd_idx_d == IDX_LAST);
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            buf_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != S_LOAD) || (wr_idx_q != '0);
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_line_slide_sequencer.sv
// Directed bench for line_slide_sequencer: fixed frames, backpressure, flush, async reset, back-to-back.
// Expected columns come from hand tables or a small rotate model.
module tb_line_slide_sequencer;
    import syzyf_slider_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        busy;
    logic [15:0] frame_cnt;

    int total;
    int bad;

    line_slide_sequencer_if bus_if ();

    line_slide_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus_if),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] slide(input logic [7:0] d, input int idx);
        logic [15:0] ext;
        int sh;
        ext = {8'h00, d};
        sh  = (2 * idx) % 16;
        if (sh == 0) return ext;
        return (ext << sh) | (ext >> (16 - sh));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n            = 1'b0;
        flush            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
    endtask

    // Feeds one column per cycle; returns with the first drain cycle visible.
    task automatic applyStimulus(input logic [7:0] vals [8], input bit keep_valid);
        for (int i = 0; i < 8; i++) begin
            checkOutput("load_in_ready", 32'(bus_if.in_ready), 32'd1);
            checkOutput("load_out_valid", 32'(bus_if.out_valid), 32'd0);
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = vals[i];
            tick();
            if (i == 0) checkOutput("load_busy", 32'(busy), 32'd1);
        end
        if (keep_valid) bus_if.in_data = 8'hAA;
        else bus_if.in_valid = 1'b0;
        checkOutput("first_drain_valid", 32'(bus_if.out_valid), 32'd1);
    endtask

    task automatic drainFrame(input logic [15:0] exp [8], input bit backpressure);
        int n = 0;
        int cycles = 0;
        while (n < 8 && cycles < 200) begin
            bus_if.out_ready = backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
            checkOutput("drain_valid", 32'(bus_if.out_valid), 32'd1);
            checkOutput("drain_in_ready", 32'(bus_if.in_ready), 32'd0);
            checkOutput("drain_data", 32'(bus_if.out_data), 32'(exp[n]));
            checkOutput("drain_idx", 32'(bus_if.out_idx), 32'(n));
            checkOutput("drain_last", 32'(bus_if.out_last), (n == 7) ? 32'd1 : 32'd0);
            if (bus_if.out_ready) n++;
            tick();
            cycles++;
        end
        if (n < 8) checkOutput("drain_timeout", 32'(n), 32'd8);
        bus_if.out_ready = 1'b0;
        checkOutput("post_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("post_in_ready", 32'(bus_if.in_ready), 32'd1);
    endtask

    logic [7:0]  vin  [8];
    logic [15:0] vexp [8];

    initial begin
        total = 0;
        bad   = 0;
        applyReset();

        checkOutput("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus_if.out_data), 32'd0);
        checkOutput("rst_out_idx", 32'(bus_if.out_idx), 32'd0);
        checkOutput("rst_out_last", 32'(bus_if.out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // Single-bit column walks up by STEP per index.
        vin  = '{default: 8'h01};
        vexp = '{16'h0001, 16'h0004, 16'h0010, 16'h0040, 16'h0100, 16'h0400, 16'h1000, 16'h4000};
        applyStimulus(vin, 1'b0);
        drainFrame(vexp, 1'b0);
        checkOutput("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);

        // Full byte wraps around the top of the output word.
        vin  = '{default: 8'hFF};
        vexp = '{16'h00FF, 16'h03FC, 16'h0FF0, 16'h3FC0, 16'hFF00, 16'hFC03, 16'hF00F, 16'hC03F};
        applyStimulus(vin, 1'b0);
        drainFrame(vexp, 1'b0);
        checkOutput("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Random backpressure: each column held until accepted.
        vin = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        for (int i = 0; i < 8; i++) vexp[i] = slide(vin[i], i);
        applyStimulus(vin, 1'b0);
        drainFrame(vexp, 1'b1);
        checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Abort a partial frame; the flush-cycle input must not be stored.
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 8'h11;
            tick();
        end
        checkOutput("t4_busy_partial", 32'(busy), 32'd1);
        flush           = 1'b1;
        bus_if.in_data  = 8'h55;
        tick();
        flush           = 1'b0;
        bus_if.in_valid = 1'b0;
        checkOutput("t4_busy_flushed", 32'(busy), 32'd0);
        checkOutput("t4_frame_cnt_flush", 32'(frame_cnt), 32'd3);
        vin = '{default: 8'h80};
        for (int i = 0; i < 8; i++) vexp[i] = slide(8'h80, i);
        applyStimulus(vin, 1'b0);
        checkOutput("t4_first_data", 32'(bus_if.out_data), 32'h0080);
        checkOutput("t4_first_idx", 32'(bus_if.out_idx), 32'd0);
        drainFrame(vexp, 1'b0);
        checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd4);

        // Asynchronous reset while column 3 is on the output.
        vin = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus(vin, 1'b0);
        begin
            int cycles = 0;
            bus_if.out_ready = 1'b1;
            while (!(bus_if.out_valid && bus_if.out_idx == 3'd3) && cycles < 20) begin
                tick();
                cycles++;
            end
            checkOutput("t5_reach_idx3", 32'(bus_if.out_idx), 32'd3);
            checkOutput("t5_idx3_data", 32'(bus_if.out_data), 32'(slide(8'h04, 3)));
        end
        bus_if.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("t5_async_data", 32'(bus_if.out_data), 32'd0);
        checkOutput("t5_async_idx", 32'(bus_if.out_idx), 32'd0);
        checkOutput("t5_async_in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        checkOutput("t5_async_frame_cnt", 32'(frame_cnt), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Back-to-back frames with in_valid never dropped.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                vin[i]  = 8'(8'h21 * (f + 1) + i);
                vexp[i] = slide(vin[i], i);
            end
            applyStimulus(vin, 1'b1);
            drainFrame(vexp, 1'b0);
            checkOutput("t6_frame_cnt", 32'(frame_cnt), 32'(f + 1));
        end
        bus_if.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
